// File: rtl/dma_pkg.sv
// dma_pkg
//   Shared types and default widths for the DMA copy sequencer.
//   state_t : sequencer states (IDLE, READ, WRITE, DONE), 2-bit encoded.
//   *_DEF   : default address / length / data widths used by the modules.
package dma_pkg;

  localparam int ADDR_W_DEF = 16;
  localparam int LEN_W_DEF  = 16;
  localparam int DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/dma_ptr_unit.sv
// dma_ptr_unit
//   Source pointer, destination pointer and remaining-byte counter for the
//   DMA copy sequencer. Pointers wrap silently modulo 2**ADDR_W.
// Ports
//   CLK, nRST          clock, asynchronous active-low reset
//   load               capture src_in/dst_in/len_in (wins over inc/dec)
//   src_in, dst_in     base addresses to load
//   len_in             byte count to load
//   src_inc            advance source pointer by one
//   dst_inc            advance destination pointer by one
//   rem_dec            decrement remaining count by one
//   src_ptr, dst_ptr   current pointers
//   remaining          bytes still to be written
//   rem_is_one         remaining == 1 (current write is the last byte)
module dma_ptr_unit
  import dma_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int LEN_W  = LEN_W_DEF
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              load,
  input  logic [ADDR_W-1:0] src_in,
  input  logic [ADDR_W-1:0] dst_in,
  input  logic [LEN_W-1:0]  len_in,
  input  logic              src_inc,
  input  logic              dst_inc,
  input  logic              rem_dec,
  output logic [ADDR_W-1:0] src_ptr,
  output logic [ADDR_W-1:0] dst_ptr,
  output logic [LEN_W-1:0]  remaining,
  output logic              rem_is_one
);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      src_ptr   <= '0;
      dst_ptr   <= '0;
      remaining <= '0;
    end else if (load) begin
      src_ptr   <= src_in;
      dst_ptr   <= dst_in;
      remaining <= len_in;
    end else begin
      if (src_inc) src_ptr   <= src_ptr + ADDR_W'(1);
      if (dst_inc) dst_ptr   <= dst_ptr + ADDR_W'(1);
      if (rem_dec) remaining <= remaining - LEN_W'(1);
    end
  end

  assign rem_is_one = (remaining == LEN_W'(1));

endmodule

// File: rtl/dma_copy_ctrl.sv
// dma_copy_ctrl
//   Byte-copy sequencer: reads one byte from the source pointer, loads it
//   into the external holding register, writes the holding register to the
//   destination pointer, and repeats for LEN bytes.
// Ports
//   CLK, nRST              clock, asynchronous active-low reset
//   start                  begin a transfer (accepted only when idle)
//   abort                  cancel the current transfer
//   src_addr, dst_addr     base addresses, sampled on accepted start
//   length                 byte count, sampled on accepted start
//   mem_ren, mem_wen       memory read / write request, held until mem_ready
//   mem_addr, mem_wdata    memory address and write data
//   mem_rdata, mem_ready   memory read data and completion
//   reg_wen, reg_wdata     holding-register load strobe and data
//   reg_data               holding-register contents
//   busy                   not idle
//   done, aborted          one-cycle completion / cancellation pulses
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for start; no memory strobes
// READ  | mem_ren at src_ptr; read data goes straight to holding reg
// WRITE | mem_wen at dst_ptr with holding-register contents
// DONE  | one cycle with done high, then back to IDLE
module dma_copy_ctrl
  import dma_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int LEN_W  = LEN_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [LEN_W-1:0]  length,
  output logic              mem_ren,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              reg_wen,
  output logic [DATA_W-1:0] reg_wdata,
  input  logic [DATA_W-1:0] reg_data,
  output logic              busy,
  output logic              done,
  output logic              aborted
);

  state_t            state;
  logic [ADDR_W-1:0] src_ptr;
  logic [ADDR_W-1:0] dst_ptr;
  logic [LEN_W-1:0]  remaining;
  logic              rem_is_one;
  logic              load;
  logic              rd_fire;
  logic              wr_fire;

  // A request completes only when the memory is ready and no abort is
  // being taken; abort wins so nothing advances on the abort cycle.
  assign load    = (state == IDLE) && start;
  assign rd_fire = (state == READ)  && mem_ready && !abort;
  assign wr_fire = (state == WRITE) && mem_ready && !abort;

  dma_ptr_unit #(
    .ADDR_W (ADDR_W),
    .LEN_W  (LEN_W)
  ) u_ptr (
    .CLK        (CLK),
    .nRST       (nRST),
    .load       (load),
    .src_in     (src_addr),
    .dst_in     (dst_addr),
    .len_in     (length),
    .src_inc    (rd_fire),
    .dst_inc    (wr_fire),
    .rem_dec    (wr_fire),
    .src_ptr    (src_ptr),
    .dst_ptr    (dst_ptr),
    .remaining  (remaining),
    .rem_is_one (rem_is_one)
  );

  // done/aborted are set on the transition, so they are high exactly in
  // the first cycle of DONE / of the IDLE that follows an abort.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state   <= IDLE;
      done    <= 1'b0;
      aborted <= 1'b0;
    end else begin
      done    <= 1'b0;
      aborted <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (length == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= READ;
            end
          end
        end
        READ: begin
          if (abort) begin
            state   <= IDLE;
            aborted <= 1'b1;
          end else if (mem_ready) begin
            state <= WRITE;
          end
        end
        WRITE: begin
          if (abort) begin
            state   <= IDLE;
            aborted <= 1'b1;
          end else if (mem_ready) begin
            if (rem_is_one) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= READ;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          if (abort) aborted <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Strobes and address decode directly from the state register, so they
  // stay stable across stalls and drop the cycle after an abort.
  assign busy      = (state != IDLE);
  assign mem_ren   = (state == READ);
  assign mem_wen   = (state == WRITE);
  assign mem_addr  = (state == READ)  ? src_ptr :
                     (state == WRITE) ? dst_ptr : '0;
  assign mem_wdata = (state == WRITE) ? reg_data : '0;

  // Read data is forwarded to the holding register in the completing cycle.
  assign reg_wen   = rd_fire;
  assign reg_wdata = rd_fire ? mem_rdata : '0;

endmodule

// File: tb/tb_dma_copy_ctrl.sv
module tb_dma_copy_ctrl;

  logic        CLK;
  logic        nRST;
  logic        start;
  logic        abort;
  logic [15:0] src_addr;
  logic [15:0] dst_addr;
  logic [15:0] length;
  logic        mem_ren;
  logic        mem_wen;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        mem_ready;
  logic        reg_wen;
  logic [7:0]  reg_wdata;
  logic [7:0]  reg_data;
  logic        busy;
  logic        done;
  logic        aborted;

  dma_copy_ctrl dut (
    .CLK       (CLK),
    .nRST      (nRST),
    .start     (start),
    .abort     (abort),
    .src_addr  (src_addr),
    .dst_addr  (dst_addr),
    .length    (length),
    .mem_ren   (mem_ren),
    .mem_wen   (mem_wen),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .reg_wen   (reg_wen),
    .reg_wdata (reg_wdata),
    .reg_data  (reg_data),
    .busy      (busy),
    .done      (done),
    .aborted   (aborted)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Memory and holding register as seen by the bench; refm is the expected
  // memory image after a plain sequential byte-by-byte forward copy.
  logic [7:0] mem  [0:65535];
  logic [7:0] refm [0:65535];
  logic [7:0] hreg;
  int    tests;
  int    fails;
  string cur;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s/%s: observed 0x%0h required 0x%0h", cur, tag, obs, exp);
    end
  endtask

  // One transfer. abort_req / reset_req name the request index (0=read of
  // byte 0, 1=write of byte 0, 2=read of byte 1 ...) to cancel on; -1 = none.
  // restart_at is a cycle at which a conflicting start is pulsed; -1 = none.
  task automatic xfer(input string nm, input logic [15:0] s, input logic [15:0] d,
                      input logic [15:0] n, input int smin, input int smax,
                      input int abort_req, input int restart_at, input int reset_req);
    int cyc, req, stall_left, total_stall, done_cyc, nexp, bad;
    bit new_req, fin, ended, wr_p, rg_p;
    logic [15:0] prev_addr, wa, a;
    logic [1:0]  prev_str;
    logic [7:0]  wd, rd;
    cur = nm;
    for (int i = 0; i < 65536; i++) refm[i] = mem[i];
    nexp = int'(n);
    @(posedge CLK); #1;
    src_addr = s; dst_addr = d; length = n; start = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
    cyc = 1; req = 0; new_req = 1; total_stall = 0; stall_left = 0;
    done_cyc = -1; fin = 0; ended = 0;
    prev_addr = '0; prev_str = '0;
    while (!fin && !ended && cyc < 3000) begin
      wr_p = 0; rg_p = 0; wa = '0; wd = '0; rd = '0;
      if (mem_ren || mem_wen) begin
        if (new_req && req == reset_req) begin
          mem_ready = 1'b0; nRST = 1'b0; #1;
          chk("rst_flags", {busy, mem_ren, mem_wen, done, aborted, reg_wen}, 0);
          chk("rst_bus", {mem_addr, mem_wdata, reg_wdata}, 0);
          @(posedge CLK); #1; nRST = 1'b1;
          bad = 0;
          for (int k = 0; k < 4; k++) begin
            @(posedge CLK); #1;
            if (busy || done || aborted || mem_ren || mem_wen) bad++;
          end
          chk("rst_quiet", bad, 0);
          nexp = req / 2;
          ended = 1;
        end else begin
          chk("one_strobe", {31'd0, mem_ren & mem_wen}, 0);
          if (new_req) begin
            a = mem_ren ? s + 16'(req / 2) : d + 16'(req / 2);
            chk(mem_ren ? "rd_addr" : "wr_addr", mem_addr, a);
            chk("req_kind", {mem_ren, mem_wen}, (req % 2 == 0) ? 2'b10 : 2'b01);
            chk("busy", busy, 1);
            stall_left = int'($urandom_range(smax, smin));
            total_stall += stall_left;
            new_req = 0;
          end else begin
            chk("stall_addr", mem_addr, prev_addr);
            chk("stall_strobe", {mem_ren, mem_wen}, prev_str);
          end
          mem_ready = (stall_left == 0);
          if (stall_left > 0) stall_left--;
          mem_rdata = mem[mem_addr];
          abort = (req == abort_req) && mem_ready;
          if (cyc == restart_at) begin
            start = 1'b1; length = 16'd9; src_addr = ~s; dst_addr = ~d;
          end
          #1;
          if (mem_ren) begin
            chk("reg_wen", reg_wen, mem_ready & ~abort);
            if (reg_wen) chk("reg_wdata", reg_wdata, mem_rdata);
          end
          wr_p = mem_wen && mem_ready; wa = mem_addr; wd = mem_wdata;
          rg_p = reg_wen; rd = reg_wdata;
          prev_addr = mem_addr; prev_str = {mem_ren, mem_wen};
          if (mem_ready) begin req++; new_req = 1; end
          if (abort) begin
            @(posedge CLK); #1;
            if (wr_p) mem[wa] = wd;
            abort = 1'b0; mem_ready = 1'b0;
            chk("abort_pulse", {aborted, busy, done, mem_ren, mem_wen}, 5'b10000);
            @(posedge CLK); #1;
            chk("abort_after", {aborted, busy, done}, 0);
            nexp = (abort_req + 1) / 2;
            ended = 1;
          end
        end
      end else begin
        mem_ready = 1'b0; #1;
        if (done) begin
          done_cyc = cyc;
          chk("busy_in_done", busy, 1);
          fin = 1;
        end
      end
      if (!ended) begin
        @(posedge CLK); #1;
        if (wr_p) mem[wa] = wd;
        if (rg_p) hreg = rd;
        reg_data = hreg;
        start = 1'b0; abort = 1'b0; mem_ready = 1'b0;
        cyc++;
      end
    end
    if (abort_req < 0 && reset_req < 0) begin
      chk("done_seen", {31'd0, fin}, 1);
      chk("done_cycle", done_cyc, 2 * int'(n) + 1 + total_stall);
      chk("after_done", {busy, done, mem_ren, mem_wen}, 0);
      @(posedge CLK); #1;
      chk("idle_stays", {busy, done}, 0);
    end
    for (int i = 0; i < nexp; i++) refm[d + 16'(i)] = refm[s + 16'(i)];
    bad = 0;
    for (int i = 0; i < 65536; i++) if (mem[i] !== refm[i]) bad++;
    chk("mem_image", bad, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tests = 0; fails = 0; cur = "reset";
    nRST = 1'b0; start = 1'b0; abort = 1'b0;
    src_addr = '0; dst_addr = '0; length = '0;
    mem_rdata = '0; mem_ready = 1'b0; hreg = '0; reg_data = '0;
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    repeat (2) @(posedge CLK);
    #1;
    chk("reset_flags", {busy, mem_ren, mem_wen, done, aborted, reg_wen}, 0);
    chk("reset_bus", {mem_addr, mem_wdata, reg_wdata}, 0);
    // start/abort while in reset are ignored
    start = 1'b1; length = 16'd5;
    @(posedge CLK); #1;
    chk("reset_hold", {busy, done}, 0);
    start = 1'b0;
    nRST = 1'b1;
    @(posedge CLK); #1;
    abort = 1'b1;
    @(posedge CLK); #1;
    abort = 1'b0;
    cur = "idle_abort";
    chk("no_effect", {busy, aborted, done}, 0);

    for (int i = 0; i < 4; i++) mem[16'h0010 + 16'(i)] = 8'hA0 + 8'(i);
    xfer("len4", 16'h0010, 16'h0100, 16'd4, 0, 0, -1, -1, -1);
    cur = "len4";
    for (int i = 0; i < 4; i++) chk("byte", mem[16'h0100 + 16'(i)], 8'hA0 + 8'(i));

    xfer("len0", 16'h0200, 16'h0300, 16'd0, 0, 0, -1, -1, -1);
    xfer("stall3", 16'h0400, 16'h0500, 16'd3, 3, 3, -1, -1, -1);
    xfer("wrap", 16'hFFFE, 16'hFFFF, 16'd3, 0, 0, -1, -1, -1);
    xfer("abort_wr", 16'h0600, 16'h0700, 16'd5, 0, 0, 3, -1, -1);
    xfer("abort_rd", 16'h0800, 16'h0900, 16'd5, 0, 2, 4, -1, -1);
    xfer("restart", 16'h0A00, 16'h0B00, 16'd4, 0, 1, -1, 3, -1);
    xfer("nrst", 16'h0C00, 16'h0D00, 16'd6, 0, 1, -1, -1, 4);

    // start and abort together in IDLE: start wins
    cur = "start_abort";
    @(posedge CLK); #1;
    src_addr = 16'h1000; dst_addr = 16'h1100; length = 16'd2; start = 1'b1; abort = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0; abort = 1'b0;
    chk("accepted", {busy, mem_ren, aborted}, 3'b110);
    nRST = 1'b0;
    @(posedge CLK); #1;
    nRST = 1'b1;

    for (int t = 0; t < 6; t++) begin
      xfer($sformatf("rand%0d", t), 16'($urandom), 16'($urandom),
           16'($urandom_range(20, 1)), 0, int'($urandom_range(3, 0)), -1, -1, -1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
